scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
Parametrised successor to the pipeline's combinational hazard detector for the RV32IM pipeline. It handles forwarding-select over a configurable number of producer stages, the same as before, and handles load-use stalls as before. It adds a sequential scoreboard for fixed-latency multiply and variable-latency divide, covering RAW, WAW and divider structural hazards. It also keeps a saturating stall-cycle counter with a cause code.

Parameters:
FWD_STAGES, 3, number of forwarding producer stages (index 0 = youngest, i.e. EX).
MUL_LAT, 3, cycles from MUL issue in EX until its result is on a forwarding stage.
SEL_W, 2, width of forward select; must be at least clog2(FWD_STAGES+1).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
rs1_id, rs2_id  in  5  ID source registers.
rs1_used_id, rs2_used_id  in  1  source actually read by the ID instruction.
rd_id  in  5  ID destination register.
reg_write_enable_id  in  1  ID instruction writes rd_id.
is_div_id  in  1  ID instruction is DIV/DIVU/REM/REMU.
issue_valid_ex  in  1  real (non-bubble) instruction in EX this cycle.
rd_ex  in  5  EX destination register.
reg_write_enable_ex  in  1  EX instruction writes rd_ex.
is_load_ex, is_mul_ex, is_div_ex  in  1  EX instruction class.
fwd_rd  in  5*FWD_STAGES  destination register per producer stage, stage i at bits [5i+4:5i].
fwd_we  in  FWD_STAGES  write enable per producer stage.
div_done  in  1  one-cycle pulse when the divider result is on stage FWD_STAGES-1.
stall_pipeline  out  1  hold IF/ID, insert bubble into EX.
forward_rs1, forward_rs2  out  SEL_W  0 = register file; i+1 = producer stage i.
div_busy  out  1  divider entry valid.
stall_cause  out  2  0 none, 1 load-use, 2 mul/div RAW or WAW, 3 divider structural.
stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset_n low, asynchronous): MUL shift entries are invalid. The div entry is invalid. stall_count is 0. All combinational outputs read 0 while reset is held.
- Forwarding (combinational):
  - For each source, take the lowest stage i with fwd_we[i], fwd_rd[i] equal to rs, and rs not 0. The select is i+1; if there is no match, the select is 0.
  - The select is computed regardless of rsN_used_id.
- MUL tracker: a MUL_LAT-entry shift register of {valid, rd}.
  - Entry 0 loads {1, rd_ex} when issue_valid_ex, is_mul_ex, reg_write_enable_ex are set and rd_ex is not 0. Otherwise entry 0 loads invalid.
  - Every entry shifts one place per cycle and leaves after MUL_LAT cycles.
  - The tracker never stalls its own shifting.
- DIV entry {valid, rd}:
  - Set on issue_valid_ex, is_div_ex, reg_write_enable_ex with rd_ex not 0.
  - Cleared on div_done.
  - If issue and div_done occur in the same cycle, issue wins and the entry reloads.
  - div_busy equals entry valid.
- Pending match: a register r is pending if any valid MUL entry has rd equal to r, or the valid div entry has rd equal to r. Register 0 is never pending.
- Stall conditions (OR of all; cause is the highest priority listed first):
  - structural (3): is_div_id, div_busy and not div_done. div_done bypasses, so no extra bubble.
  - scoreboard (2): a used rs is pending. Also WAW: reg_write_enable_id with rd_id pending in the div entry.
  - load-use (1): issue_valid_ex, is_load_ex, rd_ex not 0, and rd_ex equals a used rs.
- stall_count increments on every cycle stall_pipeline is 1 and saturates at all-ones, with no wrap.
- Latency:
  - Forward and stall outputs are combinational from inputs and state.
  - Scoreboard updates are visible the cycle after issue.
- The block does not flush the scoreboard: instructions in EX or later are always committed. The caller deasserts issue_valid_ex for bubbles and squashed instructions.

Decomposition:
- Shared package hazard_pkg holds:
  - the forward-select encodings (FWD_NONE=0, stage codes);
  - the stall_cause localparams (CAUSE_NONE, CAUSE_LOAD, CAUSE_SB, CAUSE_DIV);
  - REG_ADDR_W=5.
- One sub-module, mul_latency_tracker: MUL_LAT-deep {valid, rd} shift register with a 5-bit query port that returns a match.

Test Plan:
- Reset: assert reset_n=0 mid-MUL with entries valid -> all outputs 0 immediately. Release -> rs1=x5 not pending, stall_count=0.
- Forwarding priority: fwd_rd={x7,x7,x7}, fwd_we=3'b111, rs1_id=x7 -> forward_rs1=1. Set fwd_we=3'b110 -> forward_rs1=2. Use rs1_id=x0 -> 0.
- Load-use: load x4 in EX, ID reads rs2=x4 with rs2_used_id=1 -> stall=1, cause=1. Same with rs2_used_id=0 -> stall=0.
- MUL RAW, MUL_LAT=3: mul x9 issued at cycle t, ID reads x9 -> stall=1, cause=2 for cycles t+1..t+3. Stall=0 at t+4. stall_count advances by 3.
- Divider: div x10 issued; ID holds a second div -> cause=3 until div_done. Stall drops in the div_done cycle. ID add writing x10 while the entry is valid -> WAW stall, cause=2.
- Saturation and collisions: CNT_W=4 with a 20-cycle stall -> stall_count=15 held. Div issue coinciding with div_done -> div_busy stays 1 with the new rd.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the scoreboard hazard unit and its MUL latency tracker.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // Forward select: 0 reads the register file, i+1 selects producer stage i.
    localparam int unsigned FWD_NONE = 0;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_LOAD = 2'd1;
    localparam logic [1:0] CAUSE_SB   = 2'd2;
    localparam logic [1:0] CAUSE_DIV  = 2'd3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Outstanding long-latency write: destination register plus valid flag.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } sb_entry_t;

    function automatic int unsigned fwd_stage_code(input int stage);
        return int'(FWD_NONE) + stage + 1;
    endfunction

endpackage

// File: rtl/mul_latency_tracker.sv
// Fixed-latency MUL tracker: a MUL_LAT-deep {valid, rd} shift register that
// reports whether any queried register is still waiting on a multiply.
module mul_latency_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned NUM_QUERY = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              issue,
    input  reg_addr_t                         issue_rd,
    input  logic [NUM_QUERY*REG_ADDR_W-1:0]   query_rd,
    output logic [NUM_QUERY-1:0]              query_hit
);

    sb_entry_t [MUL_LAT-1:0] entries_q;

    // Shift every cycle; entry 0 takes the new MUL (or a bubble), the oldest falls off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '0;
        end else begin
            entries_q[0].valid <= issue;
            entries_q[0].rd    <= issue ? issue_rd : '0;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                entries_q[i] <= entries_q[i-1];
            end
        end
    end

    // Match each query against all valid entries; x0 never matches.
    always_comb begin
        query_hit = '0;
        for (int q = 0; q < int'(NUM_QUERY); q++) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                if (entries_q[i].valid &&
                    entries_q[i].rd == query_rd[q*REG_ADDR_W +: REG_ADDR_W] &&
                    query_rd[q*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                    query_hit[q] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Hazard unit for the RV32IM pipeline: forwarding select over FWD_STAGES
// producers, load-use stalls, and a scoreboard for fixed-latency MUL and
// variable-latency DIV (RAW, WAW on the divider, divider structural).
// Also keeps a saturating stall-cycle counter with the current stall cause.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned SEL_W      = 2,  // must cover FWD_STAGES+1 codes
    parameter int unsigned CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [REG_ADDR_W-1:0]             rs1_id,
    input  logic [REG_ADDR_W-1:0]             rs2_id,
    input  logic                              rs1_used_id,
    input  logic                              rs2_used_id,
    input  logic [REG_ADDR_W-1:0]             rd_id,
    input  logic                              reg_write_enable_id,
    input  logic                              is_div_id,
    input  logic                              issue_valid_ex,
    input  logic [REG_ADDR_W-1:0]             rd_ex,
    input  logic                              reg_write_enable_ex,
    input  logic                              is_load_ex,
    input  logic                              is_mul_ex,
    input  logic                              is_div_ex,
    input  logic [REG_ADDR_W*FWD_STAGES-1:0]  fwd_rd,
    input  logic [FWD_STAGES-1:0]             fwd_we,
    input  logic                              div_done,
    output logic                              stall_pipeline,
    output logic [SEL_W-1:0]                  forward_rs1,
    output logic [SEL_W-1:0]                  forward_rs2,
    output logic                              div_busy,
    output logic [1:0]                        stall_cause,
    output logic [CNT_W-1:0]                  stall_count
);

    logic             mul_issue;
    logic             div_issue;
    logic [1:0]       mul_hit;
    sb_entry_t        div_q;
    logic             rs1_pending;
    logic             rs2_pending;
    logic             div_waw;
    logic             stall_struct;
    logic             stall_sb;
    logic             stall_load;
    logic [CNT_W-1:0] stall_count_q;

    assign mul_issue = issue_valid_ex & is_mul_ex & reg_write_enable_ex & (rd_ex != '0);
    assign div_issue = issue_valid_ex & is_div_ex & reg_write_enable_ex & (rd_ex != '0);

    mul_latency_tracker #(
        .MUL_LAT   (MUL_LAT),
        .NUM_QUERY (2)
    ) u_mul_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue     (mul_issue),
        .issue_rd  (rd_ex),
        .query_rd  ({rs2_id, rs1_id}),
        .query_hit (mul_hit)
    );

    // Divider entry: a new issue wins over a same-cycle completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (div_issue) begin
            div_q.valid <= 1'b1;
            div_q.rd    <= rd_ex;
        end else if (div_done) begin
            div_q.valid <= 1'b0;
        end
    end

    // Pending lookups and the three stall sources.
    always_comb begin
        rs1_pending  = (rs1_id != '0) & (mul_hit[0] | (div_q.valid & (div_q.rd == rs1_id)));
        rs2_pending  = (rs2_id != '0) & (mul_hit[1] | (div_q.valid & (div_q.rd == rs2_id)));
        div_waw      = reg_write_enable_id & div_q.valid & (div_q.rd == rd_id) & (rd_id != '0);
        // div_done frees the unit this cycle, so a waiting DIV can follow immediately.
        stall_struct = is_div_id & div_q.valid & ~div_done;
        stall_sb     = (rs1_used_id & rs1_pending) | (rs2_used_id & rs2_pending) | div_waw;
        stall_load   = issue_valid_ex & is_load_ex & (rd_ex != '0) &
                       ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
    end

    // Stall and cause outputs, forced low while reset is held.
    always_comb begin
        stall_pipeline = 1'b0;
        stall_cause    = CAUSE_NONE;
        if (reset_n) begin
            stall_pipeline = stall_struct | stall_sb | stall_load;
            if (stall_struct) begin
                stall_cause = CAUSE_DIV;
            end else if (stall_sb) begin
                stall_cause = CAUSE_SB;
            end else if (stall_load) begin
                stall_cause = CAUSE_LOAD;
            end
        end
    end

    // Forwarding: iterate oldest to youngest so the lowest matching stage wins.
    always_comb begin
        forward_rs1 = SEL_W'(FWD_NONE);
        forward_rs2 = SEL_W'(FWD_NONE);
        if (reset_n) begin
            for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
                if (fwd_we[i] && fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs1_id && rs1_id != '0) begin
                    forward_rs1 = SEL_W'(fwd_stage_code(i));
                end
                if (fwd_we[i] && fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs2_id && rs2_id != '0) begin
                    forward_rs2 = SEL_W'(fwd_stage_code(i));
                end
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else if (stall_pipeline && stall_count_q != '1) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign div_busy    = div_q.valid;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: expected output vectors are
// queued as each cycle's stimulus is driven and popped at the falling edge.
module tb_scoreboard_hazard_unit;

    localparam int unsigned FWD_STAGES = 3;
    localparam int unsigned MUL_LAT    = 3;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned CNT_W      = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [4:0]           rs1_id, rs2_id, rd_id, rd_ex;
    logic                 rs1_used_id, rs2_used_id, reg_write_enable_id, is_div_id;
    logic                 issue_valid_ex, reg_write_enable_ex, is_load_ex, is_mul_ex, is_div_ex;
    logic [5*FWD_STAGES-1:0] fwd_rd;
    logic [FWD_STAGES-1:0]   fwd_we;
    logic                 div_done;
    logic                 stall_pipeline, div_busy;
    logic [SEL_W-1:0]     forward_rs1, forward_rs2;
    logic [1:0]           stall_cause;
    logic [CNT_W-1:0]     stall_count;

    typedef struct packed {
        logic       stall;
        logic [1:0] cause;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       busy;
    } obs_t;

    typedef struct packed {
        logic ex_v; logic ld; logic mul; logic dv; logic wex; logic [4:0] rd_ex; logic done;
        logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic [4:0] rd_id; logic wid;
        logic div_id;
    } stim_t;

    obs_t exp_q [$];
    int   n_run  = 0;
    int   n_fail = 0;

    scoreboard_hazard_unit #(
        .FWD_STAGES (FWD_STAGES),
        .MUL_LAT    (MUL_LAT),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rs1_id              (rs1_id),
        .rs2_id              (rs2_id),
        .rs1_used_id         (rs1_used_id),
        .rs2_used_id         (rs2_used_id),
        .rd_id               (rd_id),
        .reg_write_enable_id (reg_write_enable_id),
        .is_div_id           (is_div_id),
        .issue_valid_ex      (issue_valid_ex),
        .rd_ex               (rd_ex),
        .reg_write_enable_ex (reg_write_enable_ex),
        .is_load_ex          (is_load_ex),
        .is_mul_ex           (is_mul_ex),
        .is_div_ex           (is_div_ex),
        .fwd_rd              (fwd_rd),
        .fwd_we              (fwd_we),
        .div_done            (div_done),
        .stall_pipeline      (stall_pipeline),
        .forward_rs1         (forward_rs1),
        .forward_rs2         (forward_rs2),
        .div_busy            (div_busy),
        .stall_cause         (stall_cause),
        .stall_count         (stall_count)
    );

    always #5 clk = ~clk;

    // Field order: ex_v ld mul dv wex rd_ex done | rs1 u1 rs2 u2 rd_id wid div_id
    function automatic stim_t mk_s(input int ex_v, input int ld, input int mul, input int dv,
                                   input int wex, input int rdx, input int done, input int r1,
                                   input int u1, input int r2, input int u2, input int rdi,
                                   input int wid, input int divi);
        stim_t s;
        s.ex_v = ex_v[0]; s.ld = ld[0]; s.mul = mul[0]; s.dv = dv[0]; s.wex = wex[0];
        s.rd_ex = 5'(rdx); s.done = done[0]; s.rs1 = 5'(r1); s.u1 = u1[0]; s.rs2 = 5'(r2);
        s.u2 = u2[0]; s.rd_id = 5'(rdi); s.wid = wid[0]; s.div_id = divi[0];
        return s;
    endfunction

    function automatic obs_t mk(input int st, input int cause, input int f1, input int f2,
                                input int busy);
        obs_t o;
        o.stall = st[0]; o.cause = 2'(cause); o.f1 = 2'(f1); o.f2 = 2'(f2); o.busy = busy[0];
        return o;
    endfunction

    function automatic obs_t observe();
        return {stall_pipeline, stall_cause, forward_rs1, forward_rs2, div_busy};
    endfunction

    task automatic apply(input stim_t s);
        issue_valid_ex = s.ex_v; is_load_ex = s.ld; is_mul_ex = s.mul; is_div_ex = s.dv;
        reg_write_enable_ex = s.wex; rd_ex = s.rd_ex; div_done = s.done;
        rs1_id = s.rs1; rs1_used_id = s.u1; rs2_id = s.rs2; rs2_used_id = s.u2;
        rd_id = s.rd_id; reg_write_enable_id = s.wid; is_div_id = s.div_id;
    endtask

    task automatic idle();
        apply('0);
        fwd_rd = '0;
        fwd_we = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        do_reset();
        apply(mk_s(1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0));  // mul x9
        next_cycle();
        apply(mk_s(1, 0, 0, 1, 1, 10, 0, 9, 1, 0, 0, 0, 0, 0)); // div x10, ID reads x9
        exp_q.push_back(mk(1, 2, 0, 0, 0));
        @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
        if (got !== e) begin n_fail++; $display("FAIL reset_pre0 got=%b exp=%b", got, e); end
        next_cycle();
        apply(mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 5, 1, 0, 0, 1));
        fwd_rd = {5'd5, 5'd5, 5'd5};
        fwd_we = 3'b111;
        exp_q.push_back(mk(1, 3, 0, 1, 1));
        @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
        if (got !== e) begin n_fail++; $display("FAIL reset_pre1 got=%b exp=%b", got, e); end
        n_run++;
        if (stall_count !== 4'd1) begin
            n_fail++; $display("FAIL reset_precount got=%0d exp=1", stall_count);
        end
        #2 reset_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        got = observe(); e = exp_q.pop_front(); n_run++;
        if (got !== e) begin n_fail++; $display("FAIL reset_held got=%b exp=%b", got, e); end
        n_run++;
        if (stall_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_heldcount got=%0d exp=0", stall_count);
        end
        next_cycle();
        reset_n = 1'b1;
        // x9 and the div entry must be gone: only the rs2 forward remains.
        exp_q.push_back(mk(0, 0, 0, 1, 0));
        @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
        if (got !== e) begin n_fail++; $display("FAIL reset_post got=%b exp=%b", got, e); end
        n_run++;
        if (stall_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_postcount got=%0d exp=0", stall_count);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_forwarding();
        logic [14:0] frd [6];
        logic [2:0]  fwe [6];
        logic [4:0]  r1 [6];
        logic [4:0]  r2 [6];
        int          ef1 [6];
        int          ef2 [6];
        obs_t got, e;
        frd[0] = {5'd7, 5'd7, 5'd7}; fwe[0] = 3'b111; r1[0] = 5'd7; r2[0] = 5'd0; ef1[0] = 1; ef2[0] = 0;
        frd[1] = {5'd7, 5'd7, 5'd7}; fwe[1] = 3'b110; r1[1] = 5'd7; r2[1] = 5'd0; ef1[1] = 2; ef2[1] = 0;
        frd[2] = {5'd7, 5'd7, 5'd7}; fwe[2] = 3'b100; r1[2] = 5'd7; r2[2] = 5'd0; ef1[2] = 3; ef2[2] = 0;
        frd[3] = {5'd0, 5'd7, 5'd0}; fwe[3] = 3'b111; r1[3] = 5'd0; r2[3] = 5'd7; ef1[3] = 0; ef2[3] = 2;
        frd[4] = {5'd7, 5'd7, 5'd3}; fwe[4] = 3'b111; r1[4] = 5'd7; r2[4] = 5'd3; ef1[4] = 2; ef2[4] = 1;
        frd[5] = {5'd7, 5'd7, 5'd7}; fwe[5] = 3'b000; r1[5] = 5'd7; r2[5] = 5'd7; ef1[5] = 0; ef2[5] = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            fwd_rd = frd[i]; fwd_we = fwe[i]; rs1_id = r1[i]; rs2_id = r2[i];
            exp_q.push_back(mk(0, 0, ef1[i], ef2[i], 0));
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL fwd[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_load_use();
        stim_t s [5];
        obs_t  ex [5];
        obs_t  got, e;
        s[0] = mk_s(1, 1, 0, 0, 1, 4, 0, 0, 0, 4, 1, 0, 0, 0); ex[0] = mk(1, 1, 0, 0, 0);
        s[1] = mk_s(1, 1, 0, 0, 1, 4, 0, 0, 0, 4, 0, 0, 0, 0); ex[1] = mk(0, 0, 0, 0, 0);
        s[2] = mk_s(0, 1, 0, 0, 1, 4, 0, 4, 1, 0, 0, 0, 0, 0); ex[2] = mk(0, 0, 0, 0, 0);
        s[3] = mk_s(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); ex[3] = mk(0, 0, 0, 0, 0);
        s[4] = mk_s(1, 1, 0, 0, 1, 4, 0, 4, 1, 0, 0, 0, 0, 0); ex[4] = mk(1, 1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]); exp_q.push_back(ex[i]);
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        n_run++;
        if (stall_count !== 4'd2) begin
            n_fail++; $display("FAIL load_use_count got=%0d exp=2", stall_count);
        end
        idle();
    endtask

    task automatic test_mul_raw();
        obs_t got, e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) apply(mk_s(1, 0, 1, 0, 1, 9, 0, 9, 1, 0, 0, 0, 0, 0));
            else        apply(mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0));
            exp_q.push_back((i >= 1 && i <= 3) ? mk(1, 2, 0, 0, 0) : mk(0, 0, 0, 0, 0));
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL mul_raw[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        n_run++;
        if (stall_count !== 4'd3) begin
            n_fail++; $display("FAIL mul_raw_count got=%0d exp=3", stall_count);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        stim_t s [8];
        obs_t  ex [8];
        obs_t  got, e;
        s[0] = mk_s(1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);  ex[0] = mk(0, 0, 0, 0, 0);
        s[1] = mk_s(1, 0, 1, 0, 1, 12, 0, 9, 1, 0, 0, 0, 0, 0); ex[1] = mk(1, 2, 0, 0, 0);
        s[2] = mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 12, 1, 0, 0, 0); ex[2] = mk(1, 2, 0, 0, 0);
        s[3] = mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);  ex[3] = mk(1, 2, 0, 0, 0);
        s[4] = mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 12, 1, 0, 0, 0); ex[4] = mk(1, 2, 0, 0, 0);
        s[5] = mk_s(0, 0, 0, 0, 0, 0, 0, 9, 1, 12, 1, 0, 0, 0); ex[5] = mk(0, 0, 0, 0, 0);
        s[6] = mk_s(1, 0, 1, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0); ex[6] = mk(0, 0, 0, 0, 0);
        s[7] = mk_s(0, 0, 0, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0); ex[7] = mk(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(s[i]); exp_q.push_back(ex[i]);
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL b2b[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_divider();
        stim_t s [12];
        obs_t  ex [12];
        obs_t  got, e;
        s[0]  = mk_s(1, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);  ex[0]  = mk(0, 0, 0, 0, 0);
        s[1]  = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   ex[1]  = mk(1, 3, 0, 0, 1);
        s[2]  = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   ex[2]  = mk(1, 3, 0, 0, 1);
        s[3]  = mk_s(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);   ex[3]  = mk(0, 0, 0, 0, 1);
        s[4]  = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   ex[4]  = mk(0, 0, 0, 0, 0);
        s[5]  = mk_s(1, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);  ex[5]  = mk(0, 0, 0, 0, 0);
        s[6]  = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0);  ex[6]  = mk(1, 2, 0, 0, 1);
        s[7]  = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 1);  ex[7]  = mk(1, 3, 0, 0, 1);
        s[8]  = mk_s(1, 1, 0, 0, 1, 10, 0, 10, 1, 0, 0, 0, 0, 0); ex[8]  = mk(1, 2, 0, 0, 1);
        s[9]  = mk_s(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 10, 0, 0); ex[9]  = mk(0, 0, 0, 0, 1);
        s[10] = mk_s(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0);  ex[10] = mk(1, 2, 0, 0, 1);
        s[11] = mk_s(0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);  ex[11] = mk(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(s[i]); exp_q.push_back(ex[i]);
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL div[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        n_run++;
        if (stall_count !== 4'd6) begin
            n_fail++; $display("FAIL div_count got=%0d exp=6", stall_count);
        end
        idle();
    endtask

    task automatic test_collision();
        stim_t s [6];
        obs_t  ex [6];
        obs_t  got, e;
        s[0] = mk_s(1, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0); ex[0] = mk(0, 0, 0, 0, 0);
        s[1] = mk_s(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0); ex[1] = mk(0, 0, 0, 0, 1);
        s[2] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 1, 0); ex[2] = mk(1, 2, 0, 0, 1);
        s[3] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0); ex[3] = mk(0, 0, 0, 0, 1);
        s[4] = mk_s(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);  ex[4] = mk(0, 0, 0, 0, 1);
        s[5] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ex[5] = mk(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(s[i]); exp_q.push_back(ex[i]);
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL collide[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_saturation();
        obs_t got, e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(mk_s(1, 1, 0, 0, 1, 4, 0, 0, 0, 4, 1, 0, 0, 0));
            exp_q.push_back(mk(1, 1, 0, 0, 0));
            @(negedge clk); got = observe(); e = exp_q.pop_front(); n_run++;
            if (got !== e) begin n_fail++; $display("FAIL sat[%0d] got=%b exp=%b", i, got, e); end
            next_cycle();
        end
        n_run++;
        if (stall_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_count got=%0d exp=15", stall_count);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul_raw();
        test_back_to_back();
        test_divider();
        test_collision();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
